// File: rtl/dmem_ctrl.sv
// dmem_ctrl -- MEM-stage data memory access sequencer.
//
// Turns a MEM-stage load/store into one transaction on the SRAM-like data
// bus (req / addr_ok / data_ok). The block checks alignment and builds
// size, wstrb and lane-replicated wdata. It holds the pipeline until the
// access drains, then registers the raw read word for the WB-stage
// byte/half extraction.
// Lane map: addr[1:0]=00 selects bits [31:24], addr[1:0]=11 selects [7:0].
//
// Ports
//   clk, resetn            clock, synchronous active-low reset
//   mem_en_i, mem_wen_i    MEM instr is a load/store; 1 = store
//   alucontrol_i           access op (LB/LBU/LH/LHU/LW/SB/SH/SW)
//   addr_i, wdata_i        effective address, store source value
//   flush_i, m_hold_i      MEM-stage flush; MEM held by another hazard
//   req_o, wr_o, size_o    bus request, write flag, size (0=B,1=H,2=W)
//   addr_o, wstrb_o        bus address, write byte enables
//   wdata_o                lane-replicated store data
//   addr_ok_i, data_ok_i   bus address accepted, data returned/write done
//   rdata_i                bus read data
//   rdata_o, rdata_vld_o   registered raw read word, 1-cycle valid pulse
//   adel_o, ades_o         load/store address error (combinational)
//   stall_o                hold IF..MEM
//
// The op-code parameters default to a simple local encoding. Override them
// from the pipeline's control definitions at instantiation.
module dmem_ctrl #(
    parameter int                CTRL_W      = 6,
    parameter int                DATA_W      = 32,
    parameter logic [CTRL_W-1:0] LB_CONTROL  = CTRL_W'(1),
    parameter logic [CTRL_W-1:0] LBU_CONTROL = CTRL_W'(2),
    parameter logic [CTRL_W-1:0] LH_CONTROL  = CTRL_W'(3),
    parameter logic [CTRL_W-1:0] LHU_CONTROL = CTRL_W'(4),
    parameter logic [CTRL_W-1:0] LW_CONTROL  = CTRL_W'(5),
    parameter logic [CTRL_W-1:0] SB_CONTROL  = CTRL_W'(6),
    parameter logic [CTRL_W-1:0] SH_CONTROL  = CTRL_W'(7),
    parameter logic [CTRL_W-1:0] SW_CONTROL  = CTRL_W'(8)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              mem_en_i,
    input  logic              mem_wen_i,
    input  logic [CTRL_W-1:0] alucontrol_i,
    input  logic [DATA_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              flush_i,
    input  logic              m_hold_i,
    output logic              req_o,
    output logic              wr_o,
    output logic [1:0]        size_o,
    output logic [DATA_W-1:0] addr_o,
    output logic [3:0]        wstrb_o,
    output logic [DATA_W-1:0] wdata_o,
    input  logic              addr_ok_i,
    input  logic              data_ok_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              rdata_vld_o,
    output logic              adel_o,
    output logic              ades_o,
    output logic              stall_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic              discard, discard_nxt;
    logic              is_byte, is_half, is_word;
    logic              misalign, go;
    logic              issue, capture;
    logic [1:0]        size_c;
    logic [3:0]        wstrb_c;
    logic [DATA_W-1:0] wdata_c;

    // Bus fields frozen at issue; MEM inputs may change under a flush.
    logic              wr_p1;
    logic [1:0]        size_p1;
    logic [DATA_W-1:0] addr_p1;
    logic [3:0]        wstrb_p1;
    logic [DATA_W-1:0] wdata_p1;

    // ---- MEM-stage decode: access width, alignment, bus field build ----
    always_comb begin
        is_byte = 1'b0;
        is_half = 1'b0;
        is_word = 1'b0;
        case (alucontrol_i)
            LB_CONTROL, LBU_CONTROL, SB_CONTROL: is_byte = 1'b1;
            LH_CONTROL, LHU_CONTROL, SH_CONTROL: is_half = 1'b1;
            LW_CONTROL, SW_CONTROL:              is_word = 1'b1;
            default: ;
        endcase
    end

    assign misalign = (is_half & addr_i[0]) | (is_word & (addr_i[1:0] != 2'b00));
    assign adel_o   = mem_en_i & ~mem_wen_i & misalign;
    assign ades_o   = mem_en_i &  mem_wen_i & misalign;
    assign go       = mem_en_i & ~adel_o & ~ades_o & ~flush_i;

    always_comb begin
        size_c  = 2'd0;
        wstrb_c = 4'b0000;
        wdata_c = wdata_i;
        if (is_byte) begin
            size_c  = 2'd0;
            wstrb_c = 4'b1000 >> addr_i[1:0];
            wdata_c = {(DATA_W/8){wdata_i[7:0]}};
        end else if (is_half) begin
            size_c  = 2'd1;
            wstrb_c = addr_i[1] ? 4'b0011 : 4'b1100;
            wdata_c = {(DATA_W/16){wdata_i[15:0]}};
        end else if (is_word) begin
            size_c  = 2'd2;
            wstrb_c = 4'b1111;
        end
        if (!mem_wen_i) begin
            wstrb_c = 4'b0000;
        end
    end

    // ---- Bus sequencing FSM ----
    always_comb begin
        state_nxt   = state;
        discard_nxt = discard;
        req_o       = 1'b0;
        stall_o     = 1'b0;
        issue       = 1'b0;
        capture     = 1'b0;
        case (state)
            IDLE: begin
                req_o   = go;
                stall_o = go;
                issue   = go;
                if (go) begin
                    state_nxt = addr_ok_i ? DATA : ADDR;
                end
            end
            ADDR: begin
                // The request is never withdrawn once raised, even under flush.
                req_o   = 1'b1;
                stall_o = 1'b1;
                if (flush_i) begin
                    discard_nxt = 1'b1;
                end
                if (addr_ok_i) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (flush_i) begin
                    discard_nxt = 1'b1;
                end
                if (data_ok_i) begin
                    // Stall drops in the data_ok cycle so a load adds no extra bubble.
                    capture   = ~wr_p1 & ~discard & ~flush_i;
                    state_nxt = m_hold_i ? HOLD : IDLE;
                end else begin
                    stall_o = 1'b1;
                end
            end
            HOLD: begin
                // The same instr is still in MEM; wait for it to leave so it is not re-issued.
                if (!m_hold_i) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (state_nxt == IDLE) begin
            discard_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= IDLE;
            discard     <= 1'b0;
            rdata_o     <= '0;
            rdata_vld_o <= 1'b0;
        end else begin
            state       <= state_nxt;
            discard     <= discard_nxt;
            rdata_vld_o <= capture;
            if (capture) begin
                rdata_o <= rdata_i;
            end
        end
    end

    // ---- Issue latch: bus fields for the ADDR-phase re-drive ----
    always_ff @(posedge clk) begin
        if (issue) begin
            wr_p1    <= mem_wen_i;
            size_p1  <= size_c;
            addr_p1  <= addr_i;
            wstrb_p1 <= wstrb_c;
            wdata_p1 <= wdata_c;
        end
    end

    // ---- Bus field drive: live decode at issue, latched copy while waiting ----
    always_comb begin
        wr_o    = 1'b0;
        size_o  = 2'd0;
        addr_o  = '0;
        wstrb_o = 4'b0000;
        wdata_o = '0;
        if (req_o) begin
            if (state == ADDR) begin
                wr_o    = wr_p1;
                size_o  = size_p1;
                addr_o  = addr_p1;
                wstrb_o = wstrb_p1;
                wdata_o = wdata_p1;
            end else begin
                wr_o    = mem_wen_i;
                size_o  = size_c;
                addr_o  = addr_i;
                wstrb_o = wstrb_c;
                wdata_o = wdata_c;
            end
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
`timescale 1ns/1ps
module tb_dmem_ctrl;

    localparam logic [5:0] OP_LB  = 6'd1;
    localparam logic [5:0] OP_LBU = 6'd2;
    localparam logic [5:0] OP_LH  = 6'd3;
    localparam logic [5:0] OP_LHU = 6'd4;
    localparam logic [5:0] OP_LW  = 6'd5;
    localparam logic [5:0] OP_SB  = 6'd6;
    localparam logic [5:0] OP_SH  = 6'd7;
    localparam logic [5:0] OP_SW  = 6'd8;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        mem_en = 1'b0, mem_wen = 1'b0, flush = 1'b0, m_hold = 1'b0;
    logic [5:0]  alucontrol = 6'd0;
    logic [31:0] addr = 32'd0, wdata = 32'd0;
    logic        req, wr;
    logic [1:0]  size;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  wstrb;
    logic        addr_ok = 1'b0, data_ok = 1'b0;
    logic [31:0] rdata = 32'd0;
    logic [31:0] rdata_q;
    logic        rdata_vld, adel, ades, stall;

    always #5 clk = ~clk;

    dmem_ctrl #(
        .CTRL_W(6), .DATA_W(32),
        .LB_CONTROL(OP_LB), .LBU_CONTROL(OP_LBU), .LH_CONTROL(OP_LH), .LHU_CONTROL(OP_LHU),
        .LW_CONTROL(OP_LW), .SB_CONTROL(OP_SB), .SH_CONTROL(OP_SH), .SW_CONTROL(OP_SW)
    ) dut (
        .clk(clk), .resetn(resetn),
        .mem_en_i(mem_en), .mem_wen_i(mem_wen), .alucontrol_i(alucontrol),
        .addr_i(addr), .wdata_i(wdata), .flush_i(flush), .m_hold_i(m_hold),
        .req_o(req), .wr_o(wr), .size_o(size), .addr_o(bus_addr),
        .wstrb_o(wstrb), .wdata_o(bus_wdata),
        .addr_ok_i(addr_ok), .data_ok_i(data_ok), .rdata_i(rdata),
        .rdata_o(rdata_q), .rdata_vld_o(rdata_vld),
        .adel_o(adel), .ades_o(ades), .stall_o(stall)
    );

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } req_t;

    int          tests = 0;
    int          fails = 0;
    req_t        req_q[$];
    logic [31:0] rd_q[$];
    logic [31:0] ref_mem[16];
    logic [31:0] sl_mem[16];
    int          sl_a = 0;
    int          sl_d = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- reference model (from the access rules) ----------------
    function automatic int op_bytes(input logic [5:0] op_v);
        if (op_v == OP_LW || op_v == OP_SW) return 4;
        if (op_v == OP_LH || op_v == OP_LHU || op_v == OP_SH) return 2;
        return 1;
    endfunction

    function automatic bit op_store(input logic [5:0] op_v);
        return (op_v == OP_SB || op_v == OP_SH || op_v == OP_SW);
    endfunction

    function automatic bit misaligned(input logic [5:0] op_v, input logic [31:0] a);
        return (a % op_bytes(op_v)) != 0;
    endfunction

    // Byte at offset k of the word sits in lane bits [31-8k -: 8].
    function automatic req_t exp_req(input logic [5:0] op_v, input logic [31:0] a, input logic [31:0] wd);
        req_t r;
        int   n;
        int   off;
        n      = op_bytes(op_v);
        off    = int'(a % 4);
        r.wr   = op_store(op_v);
        r.size = (n == 1) ? 2'd0 : (n == 2) ? 2'd1 : 2'd2;
        r.addr = a;
        r.wstrb = 4'b0000;
        r.wdata = 32'd0;
        for (int k = 0; k < 4; k++) r.wdata[8*(3-k) +: 8] = wd[8*((n-1) - (k % n)) +: 8];
        if (r.wr) for (int b = 0; b < n; b++) r.wstrb[3-(off+b)] = 1'b1;
        return r;
    endfunction

    // ---------------- bus slave with programmable latencies ----------------
    initial begin : slave
        int          ph;
        int          cnt;
        logic        s_wr;
        logic [31:0] s_addr, s_wd;
        logic [3:0]  s_strb;
        ph = 0; cnt = 0; s_wr = 1'b0; s_addr = 32'd0; s_wd = 32'd0; s_strb = 4'd0;
        forever begin
            @(posedge clk); #2;
            addr_ok = 1'b0;
            data_ok = 1'b0;
            rdata   = $urandom;
            if (!resetn) begin
                ph = 0; cnt = 0;
            end else if (ph == 0) begin
                if (req) begin
                    if (cnt == sl_a) begin
                        addr_ok = 1'b1;
                        s_wr = wr; s_addr = bus_addr; s_wd = bus_wdata; s_strb = wstrb;
                        ph = 1; cnt = 0;
                    end else cnt++;
                end
            end else begin
                if (cnt == sl_d) begin
                    data_ok = 1'b1;
                    ph = 0; cnt = 0;
                    if (s_wr) begin
                        for (int b = 0; b < 4; b++)
                            if (s_strb[b]) sl_mem[s_addr[5:2]][8*b +: 8] = s_wd[8*b +: 8];
                    end else begin
                        rdata = sl_mem[s_addr[5:2]];
                    end
                end else cnt++;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        req_t e;
        if (mem_en) begin
            check("adel", adel, mem_en && !op_store(alucontrol) && misaligned(alucontrol, addr));
            check("ades", ades, mem_en &&  op_store(alucontrol) && misaligned(alucontrol, addr));
        end
        if (req) begin
            if (req_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL req: unexpected request at addr 0x%08h, none expected", bus_addr);
            end else begin
                e = req_q[0];
                check("req.wr", wr, e.wr);
                check("req.size", size, e.size);
                check("req.addr", bus_addr, e.addr);
                check("req.wstrb", wstrb, e.wstrb);
                if (e.wr) check("req.wdata", bus_wdata, e.wdata);
                if (addr_ok) void'(req_q.pop_front());
            end
        end
        if (rdata_vld) begin
            if (rd_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL rdata_vld: unexpected pulse, rdata 0x%08h, none expected", rdata_q);
            end else begin
                check("rdata", rdata_q, rd_q.pop_front());
            end
        end
    end

    // ---------------- driver ----------------
    // fk: cycle index of the flush pulse (-1 none); hold_n: cycles m_hold stays high from data_ok.
    task automatic run_instr(input logic [5:0] op_v, input logic [31:0] addr_v, input logic [31:0] wd_v,
                             input int a_lat, input int d_lat, input int fk, input int hold_n,
                             input string tag);
        bit          st, issue, flushed;
        int          done_c, last_c, stalls, reqs, n, off, idx;
        logic [31:0] ld_word;
        st      = op_store(op_v);
        issue   = !misaligned(op_v, addr_v) && fk != 0;
        n       = op_bytes(op_v);
        off     = int'(addr_v % 4);
        idx     = int'(addr_v[5:2]);
        ld_word = ref_mem[idx];
        done_c  = issue ? a_lat + 1 + d_lat : 0;
        last_c  = done_c + (issue ? hold_n : 0);
        sl_a = a_lat;
        sl_d = d_lat;
        if (issue) begin
            req_q.push_back(exp_req(op_v, addr_v, wd_v));
            if (st) for (int b = 0; b < n; b++) ref_mem[idx][8*(3-(off+b)) +: 8] = wd_v[8*(n-1-b) +: 8];
        end
        stalls = 0; reqs = 0; flushed = 0;
        for (int c = 0; c <= last_c; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin
                mem_en = 1'b1; mem_wen = st; alucontrol = op_v; addr = addr_v; wdata = wd_v;
            end
            flush = (c == fk);
            if (c == fk) flushed = 1;
            if (fk > 0 && c == fk) begin
                addr = $urandom; wdata = $urandom;
            end
            if (fk >= 0 && c > fk) mem_en = 1'b0;
            m_hold = issue && (c >= done_c) && (c < done_c + hold_n);
            @(negedge clk);
            if (stall) stalls++;
            if (req) reqs++;
            if (issue && !st && !flushed && c == done_c) rd_q.push_back(ld_word);
        end
        check({tag, " stall cycles"}, stalls, issue ? a_lat + 1 + d_lat : 0);
        check({tag, " req cycles"}, reqs, issue ? a_lat + 1 : 0);
    endtask

    initial begin : main
        logic [5:0]  ops[8];
        logic [5:0]  op_r;
        logic [31:0] a_r;
        int          al, dl, fk, hn, r;
        ops = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW};
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = $urandom;
            sl_mem[i]  = ref_mem[i];
        end
        ref_mem[0] = 32'hDEADBEEF;
        sl_mem[0]  = 32'hDEADBEEF;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset req", req, 0);
        check("reset stall", stall, 0);
        check("reset rdata", rdata_q, 0);
        check("reset rdata_vld", rdata_vld, 0);
        check("reset wstrb", wstrb, 0);
        @(posedge clk); #1 resetn = 1'b1;

        // directed cases
        run_instr(OP_LW, 32'h100, 32'h0, 0, 0, -1, 0, "lw_fast");
        run_instr(OP_SB, 32'h103, 32'h12345678, 1, 1, -1, 0, "sb_103");
        run_instr(OP_LH, 32'h101, 32'h0, 0, 0, -1, 0, "lh_misal");
        run_instr(OP_SW, 32'h102, 32'hCAFEF00D, 0, 0, -1, 0, "sw_misal");
        run_instr(OP_LW, 32'h104, 32'h0, 3, 2, -1, 0, "lw_slow");
        run_instr(OP_LW, 32'h108, 32'h0, 0, 3, 2, 0, "lw_flush_data");
        run_instr(OP_LW, 32'h10C, 32'h0, 0, 0, -1, 0, "lw_after_flush");
        run_instr(OP_SW, 32'h110, 32'hA5A55A5A, 0, 0, -1, 3, "sw_hold");
        run_instr(OP_LBU, 32'h111, 32'h0, 1, 0, -1, 0, "lbu_readback");
        run_instr(OP_SH, 32'h116, 32'h0000BEEF, 2, 1, 1, 0, "sh_flush_addr");
        run_instr(OP_LW, 32'h114, 32'h0, 0, 0, -1, 0, "lw_after_sh");

        // reset in the middle of the address phase
        sl_a = 50; sl_d = 0;
        req_q.push_back(exp_req(OP_LW, 32'h104, 32'h0));
        @(posedge clk); #1;
        mem_en = 1'b1; mem_wen = 1'b0; alucontrol = OP_LW; addr = 32'h104; flush = 1'b0; m_hold = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("mid reset req before", req, 1);
        @(posedge clk); #1 resetn = 1'b0; mem_en = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("mid reset req", req, 0);
        check("mid reset stall", stall, 0);
        check("mid reset addr", bus_addr, 0);
        check("mid reset vld", rdata_vld, 0);
        req_q.delete();
        @(posedge clk); #1 resetn = 1'b1;

        // randomized traffic
        for (int i = 0; i < 200; i++) begin
            op_r = ops[$urandom_range(0, 7)];
            a_r  = 32'h100 + $urandom_range(0, 63);
            if ($urandom_range(0, 9) < 7) a_r = a_r - (a_r % op_bytes(op_r));
            al = $urandom_range(0, 3);
            dl = $urandom_range(0, 3);
            fk = -1;
            r  = $urandom_range(0, 9);
            if (r == 0) fk = 0;
            else if (r <= 2 && al + dl > 0) fk = $urandom_range(1, al + dl);
            hn = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0;
            run_instr(op_r, a_r, $urandom, al, dl, fk, hn, "rnd");
        end

        @(posedge clk); #1;
        mem_en = 1'b0; flush = 1'b0; m_hold = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("pending requests", req_q.size(), 0);
        check("pending reads", rd_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
